// File: rtl/solution_serializer.sv
// solution_serializer
//   Latches a solved board on a valid_in pulse and streams it to the UART
//   transmitter as bytes. The first two bytes are a header holding the row
//   count m and the column count n. After them come the rows in order, each
//   packed LSB-first into ceil(n/8) bytes. Pacing follows tx_busy, and done
//   pulses once the final byte has been shifted out.
//
// Ports
//   clk_50mhz   in   clock
//   rst         in   synchronous, active-high reset
//   valid_in    in   one-cycle pulse; solution/m/n are valid (accepted in IDLE only)
//   solution    in   board bitmap, bit r*MAX_COLS+c is cell (r,c)
//   m, n        in   rows / columns in use (clamped to MAX_ROWS / MAX_COLS)
//   tx_busy     in   transmitter is shifting a byte
//   byte_out    out  byte to transmit, valid while byte_valid=1
//   byte_valid  out  one-cycle strobe
//   busy        out  high from latch until done
//   done        out  one-cycle pulse after the final byte completes
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for valid_in
//   LOAD   | board latched, waiting for transmitter idle before header byte 0
//   SEND   | byte_valid strobe for byte_out
//   HOLD   | one-cycle gap so the transmitter's registered busy flag is visible
//   WAIT   | waiting for tx_busy to fall, then advance or finish
//   FIN    | done pulse, then back to IDLE
module solution_serializer #(
    parameter int MAX_ROWS = 11,
    parameter int MAX_COLS = 11
) (
    input  logic                           clk_50mhz,
    input  logic                           rst,
    input  logic                           valid_in,
    input  logic [MAX_ROWS*MAX_COLS-1:0]   solution,
    input  logic [$clog2(MAX_ROWS)-1:0]    m,
    input  logic [$clog2(MAX_COLS)-1:0]    n,
    input  logic                           tx_busy,
    output logic [7:0]                     byte_out,
    output logic                           byte_valid,
    output logic                           busy,
    output logic                           done
);

    localparam int ROW_BYTES = (MAX_COLS + 7) / 8;
    localparam int MW        = $clog2(MAX_ROWS);
    localparam int NW        = $clog2(MAX_COLS);
    localparam int RW        = $clog2(MAX_ROWS + 1);
    localparam int KW        = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;
    localparam int RB        = ROW_BYTES * 8;
    localparam int NBW       = NW + 4;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    // Stream position: hdr 0 = m byte, 1 = n byte, 2 = row bytes at (row, k).
    localparam logic [1:0] P_HDR_M = 2'd0;
    localparam logic [1:0] P_HDR_N = 2'd1;
    localparam logic [1:0] P_ROWS  = 2'd2;

    logic [2:0]                    state;
    logic [MAX_ROWS*MAX_COLS-1:0]  sol_q;
    logic [MW-1:0]                 m_q;
    logic [NW-1:0]                 n_q;
    logic [1:0]                    hdr_q;
    logic [RW-1:0]                 row_q;
    logic [KW-1:0]                 k_q;

    logic [NBW-1:0]                nb;
    logic [1:0]                    nxt_hdr;
    logic [RW-1:0]                 nxt_row;
    logic [KW-1:0]                 nxt_k;
    logic                          last;
    logic [7:0]                    nxt_byte;

    function automatic logic [7:0] byte_at(input logic [1:0]    h,
                                           input logic [RW-1:0] r,
                                           input logic [KW-1:0] k);
        logic [RB-1:0] bits;
        logic [RB-1:0] mask;
        logic [7:0]    b;
        case (h)
            P_HDR_M: b = 8'(m_q);
            P_HDR_N: b = 8'(n_q);
            default: begin
                // Low RB bits after the shift may include the next row's cells;
                // the column mask removes them along with columns >= n.
                bits = RB'(sol_q >> (int'(r) * MAX_COLS));
                mask = ~({RB{1'b1}} << n_q);
                bits = bits & mask;
                b    = 8'(bits >> (int'(k) * 8));
            end
        endcase
        return b;
    endfunction

    assign nb = (NBW'(n_q) + NBW'(7)) >> 3;

    always_comb begin
        nxt_hdr = hdr_q;
        nxt_row = row_q;
        nxt_k   = k_q;
        last    = 1'b0;
        case (hdr_q)
            P_HDR_M: nxt_hdr = P_HDR_N;
            P_HDR_N: begin
                if (m_q == '0 || nb == '0) begin
                    last = 1'b1;
                end else begin
                    nxt_hdr = P_ROWS;
                    nxt_row = '0;
                    nxt_k   = '0;
                end
            end
            default: begin
                if (NBW'(k_q) + NBW'(1) == nb) begin
                    if (8'(row_q) + 8'd1 == 8'(m_q)) begin
                        last = 1'b1;
                    end else begin
                        nxt_row = row_q + RW'(1);
                        nxt_k   = '0;
                    end
                end else begin
                    nxt_k = k_q + KW'(1);
                end
            end
        endcase
        nxt_byte = byte_at(nxt_hdr, nxt_row, nxt_k);
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state    <= S_IDLE;
            sol_q    <= '0;
            m_q      <= '0;
            n_q      <= '0;
            hdr_q    <= P_HDR_M;
            row_q    <= '0;
            k_q      <= '0;
            byte_out <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_in) begin
                        sol_q <= solution;
                        m_q   <= (m > MW'(MAX_ROWS)) ? MW'(MAX_ROWS) : m;
                        n_q   <= (n > NW'(MAX_COLS)) ? NW'(MAX_COLS) : n;
                        hdr_q <= P_HDR_M;
                        row_q <= '0;
                        k_q   <= '0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!tx_busy) begin
                        byte_out <= 8'(m_q);
                        state    <= S_SEND;
                    end
                end
                S_SEND: state <= S_HOLD;
                S_HOLD: state <= S_WAIT;
                S_WAIT: begin
                    if (!tx_busy) begin
                        if (last) begin
                            state <= S_FIN;
                        end else begin
                            hdr_q    <= nxt_hdr;
                            row_q    <= nxt_row;
                            k_q      <= nxt_k;
                            byte_out <= nxt_byte;
                            state    <= S_SEND;
                        end
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign byte_valid = (state == S_SEND);
    assign done       = (state == S_FIN);
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_solution_serializer.sv
// Testbench for solution_serializer: directed scenarios with random board
// contents, checked against a byte-list model built from the packing rules.
module tb_solution_serializer;

    localparam int R  = 11;
    localparam int C  = 11;
    localparam int SW = R * C;

    logic          clk_50mhz = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [SW-1:0] solution;
    logic [3:0]    m;
    logic [3:0]    n;
    logic          tx_busy;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          busy;
    logic          done;

    solution_serializer #(.MAX_ROWS(R), .MAX_COLS(C)) dut (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .valid_in  (valid_in),
        .solution  (solution),
        .m         (m),
        .n         (n),
        .tx_busy   (tx_busy),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .busy      (busy),
        .done      (done)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    logic       uart_busy  = 1'b0;
    logic       force_busy = 1'b0;
    int         blen       = 0;
    int         ucnt       = 0;
    assign tx_busy = uart_busy | force_busy;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         done_cnt = 0;
    int         both_hi  = 0;

    // Monitor and transmitter model: sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk_50mhz);
            if (byte_valid) got.push_back(byte_out);
            if (done) done_cnt++;
            if (done && byte_valid) both_hi++;
            if (byte_valid) ucnt = blen;
            else if (ucnt > 0) ucnt--;
            uart_busy = (ucnt > 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic build_exp(input logic [SW-1:0] s, input int mm, input int nn);
        int me, ne, nb;
        logic [7:0] b;
        me = (mm > R) ? R : mm;
        ne = (nn > C) ? C : nn;
        nb = (ne + 7) / 8;
        exp_q.delete();
        exp_q.push_back(8'(me));
        exp_q.push_back(8'(ne));
        for (int r = 0; r < me; r++) begin
            for (int k = 0; k < nb; k++) begin
                b = 8'd0;
                for (int j = 0; j < 8; j++) begin
                    if (8 * k + j < ne && s[r * C + 8 * k + j]) b[j] = 1'b1;
                end
                exp_q.push_back(b);
            end
        end
    endtask

    function automatic logic [SW-1:0] rand_sol();
        logic [SW-1:0] s;
        for (int i = 0; i < SW; i++) s[i] = 1'($urandom_range(0, 1));
        return s;
    endfunction

    task automatic run_stream(input logic [SW-1:0] s, input logic [3:0] mm, input logic [3:0] nn,
                              input int bl, input int hold, input bit disturb, input int rst_at,
                              input string tag);
        bit dist_done;
        int drop;
        dist_done = 1'b0;
        drop      = 0;
        build_exp(s, int'(mm), int'(nn));
        blen     = bl;
        got.delete();
        done_cnt = 0;
        both_hi  = 0;
        if (hold > 0) force_busy = 1'b1;
        solution = s;
        m        = mm;
        n        = nn;
        valid_in = 1'b1;
        @(posedge clk_50mhz); #1;
        valid_in = 1'b0;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        if (hold > 0) begin
            repeat (hold - 1) begin @(posedge clk_50mhz); #1; end
            check({tag, "_no_strobe_while_busy"}, 32'(got.size()), 32'd0);
            force_busy = 1'b0;
            check({tag, "_still_waiting"}, 32'(byte_valid), 32'd0);
        end
        @(posedge clk_50mhz); #1;
        check({tag, "_first_strobe"}, 32'(byte_valid), 32'd1);
        check({tag, "_first_byte"}, 32'(byte_out), 32'(exp_q[0]));
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk_50mhz); #1;
            valid_in = 1'b0;
            if (done_cnt > 0) break;
            if (!busy) drop++;
            if (disturb && !dist_done && got.size() >= 5) begin
                solution  = ~s;
                m         = 4'd3;
                n         = 4'd7;
                valid_in  = 1'b1;
                dist_done = 1'b1;
            end
            if (rst_at > 0 && got.size() >= rst_at) begin
                rst = 1'b1;
                @(posedge clk_50mhz); #1;
                rst = 1'b0;
                check({tag, "_rst_byte_out"}, 32'(byte_out), 32'd0);
                check({tag, "_rst_byte_valid"}, 32'(byte_valid), 32'd0);
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_done"}, 32'(done), 32'd0);
                break;
            end
        end
        if (rst_at > 0) begin
            repeat (60) begin @(posedge clk_50mhz); #1; end
            check({tag, "_rst_no_more_bytes"}, 32'(got.size()), 32'(rst_at));
            check({tag, "_rst_no_done"}, 32'(done_cnt), 32'd0);
        end else begin
            check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
            check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i < got.size())
                    check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
            end
            check({tag, "_done_with_strobe"}, 32'(both_hi), 32'd0);
            check({tag, "_busy_dropped"}, 32'(drop), 32'd0);
            repeat (8) begin @(posedge clk_50mhz); #1; end
            check({tag, "_quiet_after_done"}, 32'(got.size() + done_cnt), 32'(exp_q.size() + 1));
            check({tag, "_idle_after_done"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [SW-1:0] s;
        rst      = 1'b1;
        valid_in = 1'b0;
        solution = '0;
        m        = 4'd0;
        n        = 4'd0;
        repeat (3) @(posedge clk_50mhz);
        #1;
        check("reset_byte_out", 32'(byte_out), 32'd0);
        check("reset_byte_valid", 32'(byte_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(posedge clk_50mhz); #1;
        check("idle_busy", 32'(busy), 32'd0);

        // Corner cells only, slow transmitter.
        s = '0;
        s[0] = 1'b1;
        s[10 * C + 10] = 1'b1;
        run_stream(s, 4'd11, 4'd11, 20, 0, 1'b0, 0, "corners");

        // Column masking: all ones, only 3 columns in use.
        s = '1;
        run_stream(s, 4'd5, 4'd3, int'($urandom_range(0, 3)), 0, 1'b0, 0, "mask");

        // Transmitter held busy for 100 cycles after the latch.
        run_stream(rand_sol(), 4'd11, 4'd11, 2, 100, 1'b0, 0, "held");

        // Second valid_in mid-stream must be ignored.
        run_stream(rand_sol(), 4'd11, 4'd11, 3, 0, 1'b1, 0, "ignore_valid");

        // Reset after byte 10, then a fresh full stream.
        s = rand_sol();
        run_stream(s, 4'd11, 4'd11, 1, 0, 1'b0, 10, "midrst");
        run_stream(s, 4'd11, 4'd11, 1, 0, 1'b0, 0, "after_rst");

        // Degenerate and clamped dimensions.
        run_stream(rand_sol(), 4'd0, 4'd11, 2, 0, 1'b0, 0, "m_zero");
        run_stream(rand_sol(), 4'd15, 4'd11, 0, 0, 1'b0, 0, "m_clamp");
        run_stream(rand_sol(), 4'd4, 4'd0, 1, 0, 1'b0, 0, "n_zero");

        // Random dimensions and pacing.
        for (int t = 0; t < 5; t++) begin
            run_stream(rand_sol(), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       int'($urandom_range(0, 4)), 0, 1'b0, 0, $sformatf("rand%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
